// File: rtl/pixel_fetch.sv
// Scan-out stage: framebuffer BRAM read, 16-entry RGB444 palette lookup and output register.
// Three register stages keep RGB, HS, VS and DEn mutually aligned.
module pixel_fetch #(
    parameter int unsigned H_VA       = 640,
    parameter int unsigned V_VA       = 480,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FB_DEPTH   = H_VA * V_VA,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iDEn,
    input  logic             iHS,
    input  logic             iVS,
    input  logic [18:0]      iPos,
    input  logic             iWrEn,
    input  logic [18:0]      iWrAddr,
    input  logic [IDX_W-1:0] iWrData,
    input  logic             iPalWe,
    input  logic [IDX_W-1:0] iPalAddr,
    input  logic [11:0]      iPalData,
    output logic [3:0]       oR,
    output logic [3:0]       oG,
    output logic [3:0]       oB,
    output logic             oHS,
    output logic             oVS,
    output logic             oDEn,
    output logic             oFrameStart,
    output logic             oWrErr
);

    localparam int unsigned PAL_N = 1 << IDX_W;

    logic [IDX_W-1:0] fb_mem [FB_DEPTH];
    logic [11:0]      pal [PAL_N];

    logic             pos_oor;
    logic             wr_oor;

    logic [IDX_W-1:0] s1_idx;
    logic             s1_den, s1_hs, s1_vs, s1_oor;
    logic [11:0]      s2_rgb;
    logic             s2_den, s2_hs, s2_vs, s2_oor;
    logic [11:0]      rgb_q;
    logic             den_q, hs_q, vs_q;
    logic             frame_start_q;
    logic             wr_err_q;

    assign pos_oor = {13'd0, iPos} >= FB_DEPTH;
    assign wr_oor  = {13'd0, iWrAddr} >= FB_DEPTH;

    // Framebuffer write port; contents survive reset.
    always_ff @(posedge iClk) begin
        if (!iRst && iWrEn && !wr_oor) begin
            fb_mem[iWrAddr] <= iWrData;
        end
    end

    // Registered read port; non-blocking semantics give read-first on collisions.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_idx <= '0;
        end else if (!pos_oor) begin
            s1_idx <= fb_mem[iPos];
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal[i] <= {3{4'(i)}};
            end
        end else if (iPalWe) begin
            pal[iPalAddr] <= iPalData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_den        <= 1'b1;
            s1_hs         <= 1'b1;
            s1_vs         <= 1'b1;
            s1_oor        <= 1'b0;
            s2_rgb        <= '0;
            s2_den        <= 1'b1;
            s2_hs         <= 1'b1;
            s2_vs         <= 1'b1;
            s2_oor        <= 1'b0;
            rgb_q         <= '0;
            den_q         <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            s1_den <= iDEn;
            s1_hs  <= iHS;
            s1_vs  <= iVS;
            s1_oor <= pos_oor;

            s2_rgb <= pal[s1_idx];
            s2_den <= s1_den;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_oor <= s1_oor;

            if (s2_den) begin
                rgb_q <= '0;
            end else if (s2_oor) begin
                rgb_q <= BORDER_RGB;
            end else begin
                rgb_q <= s2_rgb;
            end
            den_q <= s2_den;
            hs_q  <= s2_hs;
            vs_q  <= s2_vs;

            // Pulse on the edge where the output VS falls.
            frame_start_q <= vs_q && !s2_vs;
            wr_err_q      <= iWrEn && wr_oor;
        end
    end

    assign oR          = rgb_q[11:8];
    assign oG          = rgb_q[7:4];
    assign oB          = rgb_q[3:0];
    assign oDEn        = den_q;
    assign oHS         = hs_q;
    assign oVS         = vs_q;
    assign oFrameStart = frame_start_q;
    assign oWrErr      = wr_err_q;

endmodule
